// File: rtl/result_bcd_converter.sv
// Sequential binary-to-BCD converter (double dabble), one input bit per clock.
// Feeds the 7-segment decoders from the divider result register.
module result_bcd_converter #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int SW = 4 * DIGITS;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  bin_reg, bin_nxt;
  logic [SW-1:0]     scratch, scratch_nxt;
  logic [CW-1:0]     count, count_nxt;
  logic              busy_nxt, done_nxt;
  logic [SW-1:0]     bcd_nxt;
  logic [SW-1:0]     adj;
  logic [SW+WIDTH-1:0] shifted;

  // Per-digit correction: any digit >= 5 gets +3 so the following shift
  // carries into the next decimal digit. No carry between digits.
  function automatic logic [SW-1:0] add3_digits(input logic [SW-1:0] s);
    logic [SW-1:0] r;
    r = s;
    for (int d = 0; d < DIGITS; d++) begin
      if (s[4*d +: 4] >= 4'd5)
        r[4*d +: 4] = s[4*d +: 4] + 4'd3;
    end
    return r;
  endfunction

  always_comb begin
    state_nxt   = state;
    bin_nxt     = bin_reg;
    scratch_nxt = scratch;
    count_nxt   = count;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    bcd_nxt     = bcd_out;
    adj         = add3_digits(scratch);
    shifted     = {adj, bin_reg} << 1;
    case (state)
      IDLE: begin
        if (start) begin
          bin_nxt     = bin_in;
          scratch_nxt = '0;
          count_nxt   = '0;
          busy_nxt    = 1'b1;
          state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        scratch_nxt = shifted[SW+WIDTH-1:WIDTH];
        bin_nxt     = shifted[WIDTH-1:0];
        count_nxt   = count + CW'(1);
        if (count == CW'(WIDTH - 1))
          state_nxt = FINISH;
      end
      FINISH: begin
        bcd_nxt   = scratch;
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reset also clears the datapath so an abandoned conversion leaves no trace.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      bin_reg <= '0;
      scratch <= '0;
      count   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd_out <= '0;
    end else begin
      state   <= state_nxt;
      bin_reg <= bin_nxt;
      scratch <= scratch_nxt;
      count   <= count_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      bcd_out <= bcd_nxt;
    end
  end

endmodule

// File: tb/tb_result_bcd_converter.sv
// Directed bench for result_bcd_converter: latency, handshake, reset abort,
// back-to-back throughput and a full 8-bit sweep against a decimal model.
module tb_result_bcd_converter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  bin_in = '0;
  logic        busy, done;
  logic [11:0] bcd_out;

  int checks = 0;
  int passes = 0;

  result_bcd_converter #(.WIDTH(8), .DIGITS(3)) dut (
    .clk(clk), .reset(reset), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [11:0] dec_ref(input int v);
    logic [11:0] r;
    r[11:8] = 4'((v / 100) % 10);
    r[7:4]  = 4'((v / 10) % 10);
    r[3:0]  = 4'(v % 10);
    return r;
  endfunction

  // One conversion: latency to done, busy cycles, result, and done one cycle later.
  task automatic run_conv(input logic [7:0] v, output int lat, output int bcyc,
                          output logic [11:0] res, output logic done_next);
    bin_in = v;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    bin_in = ~v;
    bcyc = busy ? 1 : 0;
    lat  = -1;
    res  = 'x;
    for (int k = 1; k <= 30 && lat < 0; k++) begin
      tick();
      if (done) begin
        lat = k;
        res = bcd_out;
      end else if (busy) begin
        bcyc++;
      end
    end
    tick();
    done_next = done;
  endtask

  initial begin
    int lat, bcyc, t1, t2;
    logic [11:0] res;
    logic dn;
    logic seen;

    // Reset state
    reset = 1'b1;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bcd", bcd_out, 0);
    reset = 1'b0;
    tick();

    run_conv(8'hFF, lat, bcyc, res, dn);
    check("ff_latency", lat, 9);
    check("ff_busy_cycles", bcyc, 9);
    check("ff_bcd", res, 12'h255);
    check("ff_done_width", dn, 0);
    check("ff_bcd_held", bcd_out, 12'h255);

    run_conv(8'h00, lat, bcyc, res, dn);
    check("zero_bcd", res, 12'h000);
    check("zero_done_width", dn, 0);
    run_conv(8'h7A, lat, bcyc, res, dn);
    check("x7a_bcd", res, 12'h122);
    run_conv(8'h63, lat, bcyc, res, dn);
    check("x63_bcd", res, 12'h099);

    // Start while busy is ignored
    bin_in = 8'h0A; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    bin_in = 8'hC8; start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1;
    for (int k = 4; k <= 30 && lat < 0; k++) begin
      tick();
      if (done) begin lat = k; res = bcd_out; end
    end
    check("ignore_latency", lat, 9);
    check("ignore_bcd", res, 12'h010);
    tick();
    check("ignore_no_restart", busy, 0);
    run_conv(8'hC8, lat, bcyc, res, dn);
    check("xc8_bcd", res, 12'h200);

    // Reset mid-conversion
    bin_in = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_bcd", bcd_out, 0);
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (done) seen = 1'b1;
    end
    check("abort_no_done", seen, 0);
    check("abort_bcd_stays", bcd_out, 0);
    run_conv(8'h2D, lat, bcyc, res, dn);
    check("x2d_bcd", res, 12'h045);

    // Start held high: back-to-back conversions
    bin_in = 8'h01; start = 1'b1;
    tick();
    t1 = -1;
    for (int k = 1; k <= 30 && t1 < 0; k++) begin
      tick();
      if (done) t1 = k;
    end
    check("held_first_latency", t1, 9);
    check("held_first_bcd", bcd_out, 12'h001);
    bin_in = 8'h64;
    t2 = -1;
    for (int k = t1 + 1; k <= t1 + 30 && t2 < 0; k++) begin
      tick();
      if (done) t2 = k;
    end
    start = 1'b0;
    check("held_spacing", t2 - t1, 10);
    check("held_second_bcd", bcd_out, 12'h100);
    tick(); tick();
    check("held_stop", busy, 0);

    // Exhaustive sweep
    for (int i = 0; i < 256; i++) begin
      run_conv(8'(i), lat, bcyc, res, dn);
      check($sformatf("sweep_bcd_%0d", i), res, dec_ref(i));
      check($sformatf("sweep_digits_%0d", i),
            (res[3:0] <= 4'd9) && (res[7:4] <= 4'd9) && (res[11:8] <= 4'd9), 1);
    end
    check("sweep_latency_last", lat, 9);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
